// File: rtl/comp_seq_if.sv
// comp_seq_if: request/response bundle for the chunked comparator.
//   Request : in_valid, in_ready, a, b, signed_mode, op
//   Response: out_valid, out_ready, e, g, l, comp, cycles
//   master  - the producer/consumer side (testbench or upstream logic)
//   slave   - the comparator itself
interface comp_seq_if #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = $clog2(NCH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic             e;
    logic             g;
    logic             l;
    logic             comp;
    logic [CW-1:0]    cycles;

    modport master (
        output in_valid, a, b, signed_mode, op, out_ready,
        input  in_ready, out_valid, e, g, l, comp, cycles
    );

    modport slave (
        input  in_valid, a, b, signed_mode, op, out_ready,
        output in_ready, out_valid, e, g, l, comp, cycles
    );
endinterface

// File: rtl/comp_seq.sv
// comp_seq: sequential magnitude comparator, CHUNK bits per cycle, MSB chunk
// first, with early termination on the first unequal chunk.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : comp_seq_if.slave (request handshake, result handshake,
//              relation flags e/g/l, predicate result comp, chunk count cycles)
module comp_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic       clk,
    input logic       rst,
    comp_seq_if.slave bus
);
    localparam int NCH  = WIDTH / CHUNK;
    localparam int CW   = $clog2(NCH) + 1;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sm_q, sm_d;
    logic [2:0]       op_q, op_d;
    logic             e_q, e_d, g_q, g_d, l_q, l_d, comp_q, comp_d;
    logic [CW-1:0]    cyc_q, cyc_d;

    logic [WIDTH-1:0] a_x, b_x;
    logic [CHUNK-1:0] ca, cb;

    function automatic logic pred(input logic [2:0] op, input logic e,
                                  input logic g, input logic l);
        case (op)
            3'b000:  pred = e;
            3'b001:  pred = ~e;
            3'b010:  pred = g;
            3'b011:  pred = g | e;
            3'b100:  pred = l;
            3'b101:  pred = l | e;
            default: pred = 1'b0;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= IDXW'(NCH - 1);
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            op_q    <= 3'b000;
            e_q     <= 1'b0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            comp_q  <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            op_q    <= op_d;
            e_q     <= e_d;
            g_q     <= g_d;
            l_q     <= l_d;
            comp_q  <= comp_d;
            cyc_q   <= cyc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sm_d    = sm_q;
        op_d    = op_q;
        e_d     = e_q;
        g_d     = g_q;
        l_d     = l_q;
        comp_d  = comp_q;
        cyc_d   = cyc_q;

        // Flipping the sign bit of both operands maps two's-complement order
        // onto unsigned order; it only affects the MSB chunk.
        a_x = a_q;
        b_x = b_q;
        a_x[WIDTH-1] = a_q[WIDTH-1] ^ sm_q;
        b_x[WIDTH-1] = b_q[WIDTH-1] ^ sm_q;
        ca = a_x[int'(idx_q)*CHUNK +: CHUNK];
        cb = b_x[int'(idx_q)*CHUNK +: CHUNK];

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sm_d    = bus.signed_mode;
                    op_d    = bus.op;
                    idx_d   = IDXW'(NCH - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                // Chunks examined so far, including this one.
                cyc_d = CW'(NCH) - CW'(idx_q);
                if (ca != cb) begin
                    e_d     = 1'b0;
                    g_d     = ca > cb;
                    l_d     = ca < cb;
                    comp_d  = pred(op_q, 1'b0, ca > cb, ca < cb);
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    e_d     = 1'b1;
                    g_d     = 1'b0;
                    l_d     = 1'b0;
                    comp_d  = pred(op_q, 1'b1, 1'b0, 1'b0);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    idx_d   = IDXW'(NCH - 1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.e         = e_q;
        bus.g         = g_q;
        bus.l         = l_q;
        bus.comp      = comp_q;
        bus.cycles    = cyc_q;
    end
endmodule

// File: tb/tb_comp_seq.sv
module tb_comp_seq;
    localparam int W   = 16;
    localparam int CH  = 4;
    localparam int NCH = W / CH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    comp_seq_if #(.WIDTH(W), .CHUNK(CH)) bus ();
    comp_seq #(.WIDTH(W), .CHUNK(CH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference: relation from plain signed/unsigned arithmetic, chunk count
    // from the position of the most significant differing chunk.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sm, input logic [2:0] op,
                                  output logic me, output logic mg, output logic ml,
                                  output logic mc, output int mcyc);
        logic found;
        found = 1'b0;
        mcyc  = NCH;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (!found && a[k*CH +: CH] != b[k*CH +: CH]) begin
                found = 1'b1;
                mcyc  = NCH - k;
            end
        end
        if (sm) begin
            mg = $signed(a) > $signed(b);
            ml = $signed(a) < $signed(b);
        end else begin
            mg = a > b;
            ml = a < b;
        end
        me = (a == b);
        case (op)
            3'd0: mc = me;
            3'd1: mc = !me;
            3'd2: mc = mg;
            3'd3: mc = mg || me;
            3'd4: mc = ml;
            3'd5: mc = ml || me;
            default: mc = 1'b0;
        endcase
    endfunction

    // Issue one request, wait (bounded) for the result, hold it for `hold`
    // cycles, then consume it. lat=0 means the result never appeared.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sm, input logic [2:0] op, input int hold,
                           output int lat, output logic oe, output logic og,
                           output logic ol, output logic oc, output logic [2:0] ocyc);
        bus.a = a; bus.b = b; bus.signed_mode = sm; bus.op = op;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) lat = k;
        end
        oe = bus.e; og = bus.g; ol = bus.l; oc = bus.comp; ocyc = bus.cycles;
        repeat (hold) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({bus.in_ready, bus.out_valid, bus.e, bus.g, bus.l, bus.comp, bus.cycles} !== 9'b1_0_0000_000) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b ov=%b egl=%b%b%b comp=%b cyc=%0d, want rdy=1 ov=0 egl=000 comp=0 cyc=0",
                     bus.in_ready, bus.out_valid, bus.e, bus.g, bus.l, bus.comp, bus.cycles);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[5] = '{16'h1234, 16'h8000, 16'h8000, 16'h00A5, 16'hFFFF};
        logic [W-1:0] tb[5] = '{16'h1234, 16'h7FFF, 16'h7FFF, 16'h00A4, 16'h0001};
        logic         ts[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]   to[5] = '{3'd0, 3'd2, 3'd2, 3'd5, 3'd6};
        // Expected {e,g,l,comp}, cycles
        logic [3:0]   xf[5] = '{4'b1001, 4'b0101, 4'b0010, 4'b0100, 4'b0010};
        int           xc[5] = '{4, 1, 1, 4, 1};
        int lat; logic oe, og, ol, oc; logic [2:0] ocyc;
        for (int i = 0; i < 5; i++) begin
            run_txn(ta[i], tb[i], ts[i], to[i], 0, lat, oe, og, ol, oc, ocyc);
            n_chk++;
            if (lat != xc[i] || {oe, og, ol, oc} !== xf[i] || ocyc !== 3'(xc[i])) begin
                n_fail++;
                $display("FAIL directed_%0d: got lat=%0d egl_comp=%b%b%b%b cyc=%0d, want lat=%0d egl_comp=%b cyc=%0d",
                         i, lat, oe, og, ol, oc, ocyc, xc[i], xf[i], xc[i]);
            end
            n_chk++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL directed_%0d_consume: got ov=%b rdy=%b, want ov=0 rdy=1", i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] held; logic [2:0] hcyc; int lat;
        bus.a = 16'h00A5; bus.b = 16'h00A4; bus.signed_mode = 1'b0; bus.op = 3'd5;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) lat = k;
        end
        n_chk++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d, want 4", lat);
        end
        held = {bus.e, bus.g, bus.l, bus.comp};
        hcyc = bus.cycles;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.a = 16'h0000; bus.b = 16'hFFFF; bus.op = 3'd0;
            @(posedge clk); #1;
            n_chk++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                {bus.e, bus.g, bus.l, bus.comp} !== 4'b0100 || bus.cycles !== 3'd4 ||
                {bus.e, bus.g, bus.l, bus.comp} !== held || bus.cycles !== hcyc) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got ov=%b rdy=%b egl_comp=%b cyc=%0d, want ov=1 rdy=0 egl_comp=0100 cyc=4",
                         i, bus.out_valid, bus.in_ready, bus.e, bus.g, bus.l, bus.comp, bus.cycles);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got ov=%b rdy=%b, want ov=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        @(posedge clk); #1;
        n_chk++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_no_accept: got rdy=%b, want 1", bus.in_ready);
        end
    endtask

    task automatic test_rst_mid_run();
        int seen = 0;
        bus.a = 16'h1234; bus.b = 16'h1234; bus.signed_mode = 1'b0; bus.op = 3'd0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;          // accepted
        bus.in_valid = 1'b0;
        @(posedge clk); #1;          // first RUN cycle done
        rst = 1'b1;
        @(posedge clk); #1;          // reset lands during the second RUN cycle
        rst = 1'b0;
        n_chk++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_run: got rdy=%b ov=%b, want rdy=1 ov=0", bus.in_ready, bus.out_valid);
        end
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        n_chk++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rst_discard: got %0d valid cycles, want 0", seen);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b; logic sm; logic [2:0] op;
        logic me, mg, ml, mc; int mcyc;
        int lat; logic oe, og, ol, oc; logic [2:0] ocyc;
        for (int i = 0; i < 60; i++) begin
            a = W'($urandom);
            b = a;
            // Mostly-equal operands so every early-exit depth gets exercised.
            for (int k = 0; k < NCH; k++)
                if ($urandom_range(0, 3) == 0) b[k*CH +: CH] = CH'($urandom);
            sm = 1'($urandom);
            op = 3'($urandom_range(0, 7));
            model(a, b, sm, op, me, mg, ml, mc, mcyc);
            run_txn(a, b, sm, op, $urandom_range(0, 2), lat, oe, og, ol, oc, ocyc);
            n_chk++;
            if (lat != mcyc || {oe, og, ol, oc} !== {me, mg, ml, mc} || ocyc !== 3'(mcyc)) begin
                n_fail++;
                $display("FAIL random_%0d a=%h b=%h s=%b op=%0d: got lat=%0d egl_comp=%b%b%b%b cyc=%0d, want lat=%0d egl_comp=%b%b%b%b cyc=%0d",
                         i, a, b, sm, op, lat, oe, og, ol, oc, ocyc, mcyc, me, mg, ml, mc, mcyc);
            end
            n_chk++;
            if ($countones({oe, og, ol}) != 1) begin
                n_fail++;
                $display("FAIL random_%0d_onehot: got egl=%b%b%b, want exactly one set", i, oe, og, ol);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.signed_mode = 1'b0; bus.op = 3'd0;
        test_reset();
        test_directed();
        test_backpressure();
        test_rst_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/comp_seq.md
COMP_SEQ -- requirements
Module: comp_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of CHUNK and at least CHUNK.
REQ-002 Parameter CHUNK, default 4, bits compared per cycle; NCH = WIDTH/CHUNK chunks.
REQ-003 clk  in  1  rising-edge clock; only clock of the block.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 in_valid  in  1  request presents a, b, signed_mode, op.
REQ-006 in_ready  out  1  block can accept a request.
REQ-007 a, b  in  WIDTH  operands.
REQ-008 signed_mode  in  1  1 = two's-complement compare, 0 = unsigned.
REQ-009 op  in  3  predicate: 000 EQ, 001 NE, 010 GT, 011 GE, 100 LT, 101 LE; 110/111 reserved.
REQ-010 out_valid  out  1  result valid.
REQ-011 out_ready  in  1  consumer accepts the result.
REQ-012 e, g, l  out  1 each  one-hot relation flags: a==b, a>b, a<b.
REQ-013 comp  out  1  value of the selected predicate.
REQ-014 cycles  out  log2(NCH)+1  number of chunks examined for this result.

Function
REQ-015 FSM states: IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 IDLE with in_valid=1: on that edge, register a, b, signed_mode and op; chunk index idx=NCH-1; go to RUN. Inputs are not sampled again until the next acceptance.
REQ-017 RUN, each cycle: compare chunk [idx*CHUNK +: CHUNK] of the registered a and b, MSB chunk first.
REQ-018 For the MSB chunk with signed_mode=1, invert bit WIDTH-1 of both operands before the unsigned chunk compare.
REQ-019 Chunk unequal: on that edge, register g or l from the chunk relation (e=0) and go to DONE (early termination).
REQ-020 Chunk equal and idx>0: decrement idx and stay in RUN.
REQ-021 Chunk equal and idx==0: register e=1, g=0, l=0 and go to DONE.
REQ-022 Latency: out_valid SHALL rise k cycles after the acceptance edge, where k = chunks examined, 1..NCH; cycles = k.
REQ-023 comp values: EQ=e; NE=~e; GT=g; GE=g|e; LT=l; LE=l|e; reserved op gives comp=0 with flags still valid.
REQ-024 DONE: out_valid=1. e, g, l, comp and cycles SHALL be held stable while out_ready=0.
REQ-025 DONE with out_ready=1: result consumed on that edge; go to IDLE; out_valid=0 next cycle. No back-to-back acceptance in the same cycle.
REQ-026 in_valid SHALL be ignored in RUN and DONE; it has no effect on the in-flight result.
REQ-027 Exactly one of e, g, l SHALL be 1 whenever out_valid=1.

Reset
REQ-028 rst=1 at an edge: state=IDLE, out_valid=0, e=g=l=comp=0, cycles=0, idx=NCH-1; in_ready=1 the following cycle.
REQ-029 rst SHALL take priority over every transition, including mid-RUN and DONE; any in-flight result is discarded without out_valid.

Verification (WIDTH=16, CHUNK=4)
REQ-030 a=0x1234, b=0x1234, unsigned, op=EQ -> out_valid 4 cycles after acceptance; e=1, comp=1, cycles=4.
REQ-031 a=0x8000, b=0x7FFF, op=GT -> unsigned: g=1, comp=1, cycles=1; signed: l=1, comp=0, cycles=1.
REQ-032 a=0x00A5, b=0x00A4, unsigned, op=LE -> g=1, comp=0, cycles=4.
REQ-033 out_ready held 0 for 3 cycles in DONE while in_valid pulses -> outputs stable, in_ready=0, no new request accepted; out_ready=1 -> IDLE next cycle.
REQ-034 rst asserted during the 2nd RUN cycle -> next cycle IDLE, out_valid=0, in_ready=1, no result emitted.
REQ-035 a=0xFFFF, b=0x0001, signed, op=3'b110 -> l=1, comp=0, cycles=1.
